adc_scan_seq: RTL and testbench

- APB-programmable scan sequencer that sits in front of the ADC interface.
- Converts up to 8 programmed channels in order, one conversion at a time, on a software start or an external trigger.
- Tags each result with its channel and buffers it in a small FIFO that the CPU reads over APB.
- Raises a level interrupt on end-of-sequence, FIFO overrun, or conversion timeout.

---
 rtl/mcu_adc_seq_const_pkg.sv | 46 ++++
 rtl/adc_seq_fifo.sv | 72 +++++++
 rtl/adc_scan_seq.sv | 217 +++++++++++++++++++++
 tb/tb_adc_scan_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_adc_seq_const_pkg.sv
// Shared constants for the ADC scan sequencer: register map, field positions, reset values, FSM encoding.
// No logic of its own; zero latency.
// No flow control; constants and a pure slot-select helper only.
package mcu_adc_seq_const_pkg;

   // APB word addresses (byte offset >> 2): CR 0x00, LEN 0x04, SQR 0x08, SR 0x0C, DR 0x10
   localparam logic [9:0] WA_CR  = 10'h000;
   localparam logic [9:0] WA_LEN = 10'h001;
   localparam logic [9:0] WA_SQR = 10'h002;
   localparam logic [9:0] WA_SR  = 10'h003;
   localparam logic [9:0] WA_DR  = 10'h004;

   // CR bit positions
   localparam int CR_EN      = 0;
   localparam int CR_CONT    = 1;
   localparam int CR_TRIGSEL = 2;
   localparam int CR_START   = 3;
   localparam int CR_EOSIE   = 4;
   localparam int CR_OVRIE   = 5;
   localparam int CR_TOIE    = 6;

   // SR bit positions
   localparam int SR_EOS  = 0;
   localparam int SR_OVR  = 1;
   localparam int SR_TO   = 2;
   localparam int SR_BUSY = 3;

   // Register reset values
   localparam logic [6:0]  CR_RST  = 7'h00;
   localparam logic [2:0]  LEN_RST = 3'h0;
   localparam logic [31:0] SQR_RST = 32'h0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_START = 3'd2,
      S_CONV  = 3'd3,
      S_NEXT  = 3'd4
   } seq_state_t;

   // Channel programmed in sequence slot idx
   function automatic logic [3:0] slot_sel(input logic [31:0] sqr, input logic [2:0] idx);
      return sqr[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/adc_seq_fifo.sv
// Result FIFO: 16-bit {ch, data} entries, DEPTH deep (power of 2), flop storage.
// dout shows the head combinationally; push/pop take effect at the next PCLK edge.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module adc_seq_fifo #(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [15:0]   din,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level,
   output logic [15:0]   dout
);

   logic [15:0]   mem_q [DEPTH];
   logic [15:0]   mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   assign full  = (cnt_q == LW'(DEPTH));
   assign empty = (cnt_q == '0);
   assign level = cnt_q;
   assign dout  = mem_q[rd_ptr_q];

   // Next pointers/count; a pop frees the slot a same-cycle push into a full FIFO reuses
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      do_pop   = pop & ~empty;
      do_push  = push & (~full | do_pop);
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         cnt_d = cnt_q + LW'(do_push) - LW'(do_pop);
      end
   end

   // Storage and pointer registers
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/adc_scan_seq.sv
// APB-programmed ADC scan sequencer: up to 8 channels per sequence, results tagged and queued for the CPU.
// SW START -> ADC_START two cycles after the setup phase; ext trigger -> ADC_START 3 cycles after the edge.
// No backpressure to the ADC: a result arriving with the FIFO full is dropped and flagged OVR.
module adc_scan_seq
   import mcu_adc_seq_const_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 64
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        PSEL,
   input  logic [11:2] PADDR,
   input  logic        PENABLE,
   input  logic        PWRITE,
   input  logic [31:0] PWDATA,
   output logic [31:0] PRDATA,
   output logic        PREADY,
   output logic        PSLVERR,
   input  logic        ADC_READY,
   input  logic        ADC_DONE,
   input  logic [11:0] ADC_DATA,
   input  logic        TRIG_IN,
   output logic        ADC_START,
   output logic [3:0]  ADC_CHSEL,
   output logic        SEQ_INT
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   seq_state_t    state_q, state_d;
   logic [6:0]    cr_q, cr_d;
   logic [2:0]    len_q, len_d;
   logic [31:0]   sqr_q, sqr_d;
   logic          eos_q, eos_d, ovr_q, ovr_d, to_q, to_d;
   logic [2:0]    idx_q, idx_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          sync1_q, sync2_q, sync3_q;
   logic          adc_start_q, adc_start_d;
   logic [3:0]    chsel_q, chsel_d;
   logic          int_q, int_d;
   logic [31:0]   prdata_q, prdata_d;

   logic          wr_en, rd_en, wr_cr, wr_sr, en_d, trig_pulse, busy, leave_wait;
   logic          eos_set, to_set, ovr_set;
   logic          fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
   logic [LW-1:0] fifo_level;
   logic [15:0]   fifo_din, fifo_dout;
   logic [31:0]   rdata;

   assign PREADY  = 1'b1;
   assign PSLVERR = 1'b0;
   assign PRDATA    = prdata_q;
   assign ADC_START = adc_start_q;
   assign ADC_CHSEL = chsel_q;
   assign SEQ_INT   = int_q;

   assign wr_en = PSEL & PWRITE & ~PENABLE;
   assign rd_en = PSEL & ~PWRITE & ~PENABLE;
   assign wr_cr = wr_en & (PADDR == WA_CR);
   assign wr_sr = wr_en & (PADDR == WA_SR);
   // EN as it will be after this edge, so a disable acts in the same cycle it is written
   assign en_d  = wr_cr ? PWDATA[CR_EN] : cr_q[CR_EN];

   assign trig_pulse = sync2_q & ~sync3_q;
   assign busy       = state_q inside {S_START, S_CONV, S_NEXT};
   assign fifo_din   = {slot_sel(sqr_q, idx_q), ADC_DATA};
   assign fifo_flush = ~en_d;
   assign fifo_pop   = rd_en & (PADDR == WA_DR) & ~fifo_empty;
   assign ovr_set    = fifo_push & fifo_full & ~fifo_pop;
   assign leave_wait = (state_q == S_WAIT) && (state_d != S_WAIT);

   // Sequencer next state, slot index, timeout counter and result push
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      fifo_push = 1'b0;
      eos_set   = 1'b0;
      to_set    = 1'b0;
      case (state_q)
         S_IDLE:  state_d = S_WAIT;
         S_WAIT: begin
            if (ADC_READY && (cr_q[CR_TRIGSEL] ? trig_pulse : cr_q[CR_START])) begin
               state_d = S_START;
            end
         end
         S_START: begin
            cnt_d   = '0;
            state_d = S_CONV;
         end
         S_CONV: begin
            if (ADC_DONE) begin
               fifo_push = 1'b1;
               state_d   = S_NEXT;
            end else if (cnt_q == TW'(TIMEOUT - 1)) begin
               to_set  = 1'b1;
               idx_d   = '0;
               state_d = S_WAIT;
            end else begin
               cnt_d = cnt_q + TW'(1);
            end
         end
         S_NEXT: begin
            if (idx_q == len_q) begin
               eos_set = 1'b1;
               idx_d   = '0;
               state_d = cr_q[CR_CONT] ? S_START : S_WAIT;
            end else begin
               idx_d   = idx_q + 3'd1;
               state_d = S_START;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Disable wins from any state; an in-flight result is discarded
      if (!en_d) begin
         state_d   = S_IDLE;
         idx_d     = '0;
         fifo_push = 1'b0;
      end
   end

   // Register file, status flags (set beats W1C), interrupt, ADC outputs and read data
   always_comb begin
      cr_d  = cr_q;
      len_d = len_q;
      sqr_d = sqr_q;
      if (wr_en) begin
         case (PADDR)
            WA_CR:   cr_d  = PWDATA[6:0];
            WA_LEN:  len_d = PWDATA[2:0];
            WA_SQR:  sqr_d = PWDATA;
            default: ;
         endcase
      end
      if (leave_wait || !en_d) begin
         cr_d[CR_START] = 1'b0;
      end
      eos_d = (eos_q & ~(wr_sr & PWDATA[SR_EOS])) | eos_set;
      ovr_d = (ovr_q & ~(wr_sr & PWDATA[SR_OVR])) | ovr_set;
      to_d  = (to_q  & ~(wr_sr & PWDATA[SR_TO]))  | to_set;
      int_d = (eos_q & cr_q[CR_EOSIE]) | (ovr_q & cr_q[CR_OVRIE]) | (to_q & cr_q[CR_TOIE]);
      adc_start_d = (state_d == S_START);
      chsel_d     = (state_d == S_START) ? slot_sel(sqr_q, idx_d) : chsel_q;
      case (PADDR)
         WA_CR:   rdata = {25'h0, cr_q};
         WA_LEN:  rdata = {29'h0, len_q};
         WA_SQR:  rdata = sqr_q;
         WA_SR:   rdata = {23'h0, 5'(fifo_level), busy, to_q, ovr_q, eos_q};
         WA_DR:   rdata = fifo_empty ? 32'h0 : {16'h0, fifo_dout};
         default: rdata = 32'h0;
      endcase
      prdata_d = rd_en ? rdata : prdata_q;
   end

   // FSM state register
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath, register and trigger-synchroniser flops
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         cr_q        <= CR_RST;
         len_q       <= LEN_RST;
         sqr_q       <= SQR_RST;
         eos_q       <= 1'b0;
         ovr_q       <= 1'b0;
         to_q        <= 1'b0;
         idx_q       <= '0;
         cnt_q       <= '0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         sync3_q     <= 1'b0;
         adc_start_q <= 1'b0;
         chsel_q     <= '0;
         int_q       <= 1'b0;
         prdata_q    <= '0;
      end else begin
         cr_q        <= cr_d;
         len_q       <= len_d;
         sqr_q       <= sqr_d;
         eos_q       <= eos_d;
         ovr_q       <= ovr_d;
         to_q        <= to_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         sync1_q     <= TRIG_IN;
         sync2_q     <= sync1_q;
         sync3_q     <= sync2_q;
         adc_start_q <= adc_start_d;
         chsel_q     <= chsel_d;
         int_q       <= int_d;
         prdata_q    <= prdata_d;
      end
   end

   adc_seq_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .flush   (fifo_flush),
      .din     (fifo_din),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level),
      .dout    (fifo_dout)
   );

endmodule

// File: tb/tb_adc_scan_seq.sv
// Directed bench for adc_scan_seq: APB programming, sequencing, trigger, timeout, overrun and disable.
// Inputs driven and outputs sampled on the falling edge.
// Every bus wait and ADC wait is bounded by a cycle budget.
module tb_adc_scan_seq;

   logic        PCLK = 1'b0;
   logic        PRESETn;
   logic        PSEL, PENABLE, PWRITE;
   logic [11:2] PADDR;
   logic [31:0] PWDATA, PRDATA;
   logic        PREADY, PSLVERR;
   logic        ADC_READY, ADC_DONE, TRIG_IN;
   logic [11:0] ADC_DATA;
   logic        ADC_START, SEQ_INT;
   logic [3:0]  ADC_CHSEL;

   int n_chk = 0;
   int n_err = 0;

   always #5 PCLK = ~PCLK;

   adc_scan_seq #(.FIFO_DEPTH(8), .TIMEOUT(64)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
      .ADC_READY(ADC_READY), .ADC_DONE(ADC_DONE), .ADC_DATA(ADC_DATA), .TRIG_IN(TRIG_IN),
      .ADC_START(ADC_START), .ADC_CHSEL(ADC_CHSEL), .SEQ_INT(SEQ_INT)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge PCLK);
   endtask

   task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a[11:2]; PWDATA = d;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a[11:2];
      @(negedge PCLK);
      PENABLE = 1'b1;
      d = PRDATA;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic wait_start(input string tag, input logic [3:0] exp_ch);
      int k = 0;
      while (!ADC_START && k < 100) begin
         @(negedge PCLK);
         k++;
      end
      chk({tag, "_seen"}, 32'(ADC_START), 32'd1);
      chk({tag, "_ch"}, 32'(ADC_CHSEL), 32'(exp_ch));
   endtask

   // Called in the ADC_START cycle: answers one cycle later
   task automatic conv(input logic [11:0] d);
      @(negedge PCLK);
      ADC_DONE = 1'b1; ADC_DATA = d;
      @(negedge PCLK);
      ADC_DONE = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] rd;
      int first, cnt, found;

      PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
      ADC_READY = 1'b1; ADC_DONE = 1'b0; ADC_DATA = '0; TRIG_IN = 1'b0;
      idle(3);
      chk("rst_adc_start", 32'(ADC_START), 32'd0);
      chk("rst_chsel", 32'(ADC_CHSEL), 32'd0);
      chk("rst_seq_int", 32'(SEQ_INT), 32'd0);
      chk("rst_prdata", PRDATA, 32'd0);
      chk("pready", 32'(PREADY), 32'd1);
      chk("pslverr", 32'(PSLVERR), 32'd0);
      PRESETn = 1'b1;
      idle(1);
      apb_read(12'h00C, rd); chk("rst_sr", rd, 32'h0);
      apb_read(12'h000, rd); chk("rst_cr", rd, 32'h0);

      // ---- three-channel SW sequence ----
      apb_write(12'h000, 32'h11);
      apb_write(12'h004, 32'd2);
      apb_write(12'h008, 32'h0000_0531);
      apb_write(12'h000, 32'h19);
      chk("sw_start_latency", 32'(ADC_START), 32'd1);
      wait_start("seq0", 4'd1);
      conv(12'h111);
      wait_start("seq1", 4'd3);
      conv(12'h222);
      wait_start("seq2", 4'd5);
      conv(12'h333);
      idle(3);
      chk("eos_int", 32'(SEQ_INT), 32'd1);
      apb_read(12'h00C, rd); chk("sr_after_seq", rd, 32'h31);
      apb_read(12'h000, rd); chk("cr_start_cleared", rd, 32'h11);
      apb_read(12'h010, rd); chk("dr0", rd, 32'h1111);
      apb_read(12'h010, rd); chk("dr1", rd, 32'h3222);
      apb_read(12'h010, rd); chk("dr2", rd, 32'h5333);
      apb_read(12'h010, rd); chk("dr_empty", rd, 32'h0);
      apb_read(12'h020, rd); chk("unmapped", rd, 32'h0);
      apb_write(12'h00C, 32'h1);
      idle(1);
      chk("eos_int_cleared", 32'(SEQ_INT), 32'd0);

      // ---- continuous mode overrun, then pop+push while full ----
      apb_write(12'h000, 32'h0);
      apb_write(12'h00C, 32'h7);
      apb_write(12'h004, 32'd0);
      apb_write(12'h000, 32'h0B);
      for (int i = 0; i < 9; i++) begin
         wait_start("cont", 4'd1);
         conv(12'h100 + 12'(i));
      end
      idle(1);
      apb_read(12'h00C, rd); chk("sr_overrun", rd, 32'h8B);
      apb_read(12'h010, rd); chk("dr_first_kept", rd, 32'h1100);
      apb_write(12'h00C, 32'h3);
      ADC_DONE = 1'b1; ADC_DATA = 12'h109;
      @(negedge PCLK);
      ADC_DONE = 1'b0;
      idle(2);
      apb_read(12'h00C, rd); chk("sr_refull", rd, 32'h89);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 10'h004;
      ADC_DONE = 1'b1; ADC_DATA = 12'h10A;
      @(negedge PCLK);
      ADC_DONE = 1'b0; PENABLE = 1'b1;
      rd = PRDATA;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0;
      chk("dr_pop_while_push", rd, 32'h1101);
      idle(2);
      apb_read(12'h00C, rd); chk("sr_full_pop_push", rd, 32'h89);

      // ---- external trigger ----
      apb_write(12'h000, 32'h0);
      apb_write(12'h00C, 32'h7);
      apb_write(12'h000, 32'h05);
      idle(2);
      first = 0; cnt = 0;
      TRIG_IN = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge PCLK);
         if (k == 5) TRIG_IN = 1'b0;
         if (ADC_START) begin
            cnt++;
            if (first == 0) first = k;
         end
      end
      chk("trig_start_count", 32'(cnt), 32'd1);
      chk("trig_latency_3_4", 32'((first >= 3) && (first <= 4)), 32'd1);
      ADC_DONE = 1'b1; ADC_DATA = 12'hABC;
      @(negedge PCLK);
      ADC_DONE = 1'b0;
      idle(3);
      apb_read(12'h010, rd); chk("trig_dr", rd, 32'h1ABC);
      cnt = 0;
      ADC_READY = 1'b0;
      TRIG_IN = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(negedge PCLK);
         if (k == 5) TRIG_IN = 1'b0;
         if (k == 8) ADC_READY = 1'b1;
         if (ADC_START) cnt++;
      end
      chk("trig_lost_not_ready", 32'(cnt), 32'd0);

      // ---- timeout, then disable mid-sequence ----
      apb_write(12'h000, 32'h0);
      apb_write(12'h00C, 32'h7);
      apb_write(12'h004, 32'd2);
      apb_write(12'h000, 32'h41);
      apb_write(12'h000, 32'h49);
      chk("to_first_start", 32'(ADC_START), 32'd1);
      conv(12'h0AA);
      wait_start("to_slot1", 4'd3);
      found = 0;
      for (int d = 1; d <= 100 && found == 0; d++) begin
         @(negedge PCLK);
         if (SEQ_INT) found = d;
      end
      chk("to_int_delay_65_66", 32'((found >= 65) && (found <= 66)), 32'd1);
      apb_read(12'h00C, rd); chk("sr_timeout", rd, 32'h14);
      apb_write(12'h00C, 32'h4);
      apb_read(12'h00C, rd); chk("sr_to_w1c", rd, 32'h10);
      chk("to_int_cleared", 32'(SEQ_INT), 32'd0);
      apb_write(12'h000, 32'h49);
      chk("restart_after_to", 32'(ADC_START), 32'd1);
      chk("idx_reset_after_to", 32'(ADC_CHSEL), 32'd1);
      conv(12'h0BB);
      wait_start("dis_slot1", 4'd3);
      @(negedge PCLK);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = 10'h000; PWDATA = 32'h0;
      ADC_DONE = 1'b1; ADC_DATA = 12'hEEE;
      @(negedge PCLK);
      ADC_DONE = 1'b0; PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      apb_read(12'h00C, rd); chk("sr_disabled", rd, 32'h0);
      ADC_DONE = 1'b1; ADC_DATA = 12'hDDD;
      @(negedge PCLK);
      ADC_DONE = 1'b0;
      idle(1);
      apb_read(12'h00C, rd); chk("sr_late_done", rd, 32'h0);
      apb_read(12'h010, rd); chk("dr_after_disable", rd, 32'h0);
      chk("no_start_idle", 32'(ADC_START), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
